mips_alu_mc: RTL and testbench
==============================

Name: mips_alu_mc

Overview:
Parametrised multicycle ALU, the next generation of the execute-stage ALU. Keeps the MIPS op set and adds an iterative shifter, an iterative unsigned multiplier, signed/unsigned set-less-than and a signed overflow flag. Uses valid/ready handshakes on both sides so the execute stage can stall on long ops. All outputs are registered.

Parameters:
WIDTH, 32, datapath width; must be an even power of two, at least 8.
SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request this cycle.
op  input  4  opcode (see Behaviour).
a  input  WIDTH  operand A; a[SHW-1:0] is the variable shift amount.
b  input  WIDTH  operand B; the shifted and LUI source.
shamt  input  SHW  immediate shift amount.
var_sh  input  1  1 = shift by a[SHW-1:0]; 0 = shift by shamt.
out_valid  output  1  result, hi and flags are valid.
out_ready  input  1  consumer takes the result.
result  output  WIDTH  low result.
hi  output  WIDTH  high product word (MULU only; 0 for other ops).
zero  output  1  result == 0.
sign  output  1  result[WIDTH-1].
ovf  output  1  signed overflow (ADD/SUB only; 0 otherwise).

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 OR, 3 LUI = {b[WIDTH/2-1:0], WIDTH/2 zeros}, 4 AND, 5 XOR, 6 NOR.
  - 7 SLT signed, 8 SLTU: result = {0..., 1'b1} when true, else 0.
  - 9 SLL, 10 SRL, 11 SRA (fills with b[WIDTH-1]), 12 MULU ({hi, result} = a*b, unsigned).
  - 13-15 reserved: single-cycle, result = 0, hi = 0.
- Reset (async): state IDLE; out_valid 0; result, hi, zero, sign, ovf all 0. in_ready follows the IDLE rule below.
- Accept: a handshake occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- a, b, op, shamt and var_sh are captured at accept. Input changes after accept have no effect.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE: on accept of a single-cycle op (0-8, 13-15), result, hi and flags load at the same edge; out_valid = 1 on the next cycle (latency 1).
  - IDLE -> SHIFT on accept of 9-11 with effective amount n > 0. Shift one bit per cycle. After n cycles, load result, set out_valid, return to IDLE. Latency n+1. With n == 0, result = b at latency 1.
  - IDLE -> MUL on accept of 12. Shift-add, one bit per cycle, WIDTH cycles. Then load {hi, result}, set out_valid, return to IDLE. Latency WIDTH+1.
- Output hold: out_valid stays high, and result, hi and flags stay stable, until out_ready is seen high. out_valid drops on the edge after out_ready, unless a new op completes on that same edge.
- Back-to-back: with out_valid && out_ready, a new accept in the same cycle is legal. Single-cycle ops then sustain 1 op/cycle.
- Flags: zero and sign are computed from the final result and registered with it.
  - ovf: ADD = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - ovf: SUB = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
- Arithmetic wraps modulo 2^WIDTH. There are no exceptions.
- Reset mid-operation aborts the op immediately: state IDLE, out_valid 0, partial state discarded.
- in_ready is low during SHIFT and MUL. in_valid held high is simply not accepted until the block returns to IDLE.

Optional Feature:
ALU_BARREL_SHIFT_EN:
- Defined: SLL/SRL/SRA are computed by a combinational barrel shifter and complete at latency 1, like the other single-cycle ops. The SHIFT state is not built.
- Undefined: the iterative SHIFT behaviour above applies.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> out_valid after 1 cycle; result 0x80000000, ovf 1, sign 1, zero 0.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1 back-to-back with out_ready=1 -> results 0 (zero 1), then 1; one result per cycle.
- SRA b=0x80000000, var_sh=1, a=4 -> result 0xF8000000; out_valid after 5 cycles (1 with ALU_BARREL_SHIFT_EN); in_ready low meanwhile.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi 0xFFFFFFFE, result 0x00000001 after 33 cycles.
- LUI b=0x0000ABCD with out_ready=0 for 3 cycles -> result 0xABCD0000 held stable, in_ready low; output released on the cycle out_ready=1.
- rst asserted at cycle 10 of a MULU -> out_valid 0, all outputs 0, in_ready 1; next ADD 2+3 -> 5.

Source files
------------

// File: rtl/mips_alu_mc.sv
// ============================================================================
// Module   : mips_alu_mc
// Purpose  : Multicycle MIPS execute ALU with valid/ready handshakes,
//            iterative shifter and shift-add unsigned multiplier.
//            Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             var_sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             sign,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  // sreg holds the shift operand, or the multiplier / low product during MUL
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [SHW:0]     cnt_q, cnt_d;
`ifndef ALU_BARREL_SHIFT_EN
  logic [1:0]       kind_q, kind_d;
`endif

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic             is_shift;
  logic             cnt_last;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign amt       = var_sh ? a[SHW-1:0] : shamt;
  assign sum       = a + b;
  assign diff      = a - b;
  assign is_shift  = (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  assign cnt_last  = (cnt_q == (SHW+1)'(1));

  assign msum      = {1'b0, phi_q} + (sreg_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi    = msum[WIDTH:1];
  assign mul_lo    = {msum[0], sreg_q[WIDTH-1:1]};

`ifndef ALU_BARREL_SHIFT_EN
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic [1:0] k);
    case (k)
      2'd1:    shift1 = {v[WIDTH-2:0], 1'b0};
      2'd2:    shift1 = {1'b0, v[WIDTH-1:1]};
      default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  logic [WIDTH-1:0] sh_next;
  assign sh_next = shift1(sreg_q, kind_q);
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2:  alu_res = a | b;
      4'd3:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd4:  alu_res = a & b;
      4'd5:  alu_res = a ^ b;
      4'd6:  alu_res = ~(a | b);
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
      4'd9:  alu_res = b << amt;
      4'd10: alu_res = b >> amt;
      4'd11: alu_res = $unsigned($signed(b) >>> amt);
`else
      // Zero-distance shifts finish here; nonzero ones go to SHIFT
      4'd9, 4'd10, 4'd11: alu_res = b;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    sreg_d      = sreg_q;
    phi_d       = phi_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
`ifndef ALU_BARREL_SHIFT_EN
    kind_d      = kind_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == 4'd12) begin
            state_d = MUL;
            phi_d   = '0;
            sreg_d  = b;
            mcand_d = a;
            cnt_d   = (SHW+1)'(WIDTH);
`ifndef ALU_BARREL_SHIFT_EN
          end else if (is_shift && (amt != '0)) begin
            state_d = SHIFT;
            sreg_d  = b;
            kind_d  = op[1:0];
            cnt_d   = {1'b0, amt};
`endif
          end else begin
            result_d    = alu_res;
            hi_d        = '0;
            zero_d      = (alu_res == '0);
            sign_d      = alu_res[MSB];
            ovf_d       = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: begin
        sreg_d = sh_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_last) begin
          state_d     = IDLE;
          result_d    = sh_next;
          hi_d        = '0;
          zero_d      = (sh_next == '0);
          sign_d      = sh_next[MSB];
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
`endif
      MUL: begin
        phi_d  = mul_hi;
        sreg_d = mul_lo;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_last) begin
          state_d     = IDLE;
          result_d    = mul_lo;
          hi_d        = mul_hi;
          zero_d      = (mul_lo == '0);
          sign_d      = mul_lo[MSB];
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sreg_q      <= '0;
      phi_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
`ifndef ALU_BARREL_SHIFT_EN
      kind_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      sreg_q      <= sreg_d;
      phi_q       <= phi_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
`ifndef ALU_BARREL_SHIFT_EN
      kind_q      <= kind_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_mc.sv
// ============================================================================
// Module   : tb_mips_alu_mc
// Purpose  : Self-checking bench for mips_alu_mc (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic        var_sh = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        sign;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        vs;
    logic [31:0] res;
    logic [31:0] hi;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  mips_alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt), .var_sh(var_sh),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .hi(hi), .zero(zero), .sign(sign), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0h expected no output", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_result", 64'(result), 64'(e.res));
        chk("sb_hi",     64'(hi),     64'(e.hi));
        chk("sb_ovf",    64'(ovf),    64'(e.ovf));
        chk("sb_zero",   64'(zero),   64'(e.res == 32'h0));
        chk("sb_sign",   64'(sign),   64'(e.res[31]));
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [4:0] sa, input logic vs,
                      input logic [31:0] er, input logic [31:0] eh, input logic eo);
    exp_t e;
    bit   ok;
    op = o; a = aa; b = bb; shamt = sa; var_sh = vs; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.res = er; e.hi = eh; e.ovf = eo;
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
  endtask

  // Cycles from the accept edge until out_valid is seen (1 = next cycle).
  task automatic latency(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  vec_t vecs[22];
  int   lat;

  initial begin
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 32'h0, 1'b1};
    vecs[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[2]  = '{4'd1,  32'h80000000, 32'h00000001, 5'd0,  1'b0, 32'h7FFFFFFF, 32'h0, 1'b1};
    vecs[3]  = '{4'd1,  32'h00000005, 32'h00000005, 5'd0,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[4]  = '{4'd2,  32'hF0F00000, 32'h0000F0F0, 5'd0,  1'b0, 32'hF0F0F0F0, 32'h0, 1'b0};
    vecs[5]  = '{4'd3,  32'hFFFFFFFF, 32'h1234ABCD, 5'd0,  1'b0, 32'hABCD0000, 32'h0, 1'b0};
    vecs[6]  = '{4'd4,  32'hFF00FF00, 32'h0FF00FF0, 5'd0,  1'b0, 32'h0F000F00, 32'h0, 1'b0};
    vecs[7]  = '{4'd5,  32'hAAAAAAAA, 32'hFFFF0000, 5'd0,  1'b0, 32'h5555AAAA, 32'h0, 1'b0};
    vecs[8]  = '{4'd6,  32'h00000000, 32'h00000000, 5'd0,  1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[9]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000001, 32'h0, 1'b0};
    vecs[10] = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[11] = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[12] = '{4'd8,  32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000001, 32'h0, 1'b0};
    vecs[13] = '{4'd9,  32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 32'h0, 1'b0};
    vecs[14] = '{4'd10, 32'hFFFFFF08, 32'hF0000000, 5'd3,  1'b1, 32'h00F00000, 32'h0, 1'b0};
    vecs[15] = '{4'd11, 32'h00000000, 32'h80000000, 5'd0,  1'b0, 32'h80000000, 32'h0, 1'b0};
    vecs[16] = '{4'd11, 32'h00000000, 32'h40000000, 5'd4,  1'b0, 32'h04000000, 32'h0, 1'b0};
    vecs[17] = '{4'd12, 32'h00010000, 32'h00010000, 5'd0,  1'b0, 32'h00000000, 32'h1, 1'b0};
    vecs[18] = '{4'd12, 32'h12345678, 32'h00000002, 5'd0,  1'b0, 32'h2468ACF0, 32'h0, 1'b0};
    vecs[19] = '{4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[20] = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd0,  1'b0, 32'h00000000, 32'h0, 1'b0};
    vecs[21] = '{4'd10, 32'h0000001F, 32'h80000000, 5'd0,  1'b1, 32'h00000001, 32'h0, 1'b0};

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_hi",        64'(hi),        64'd0);
    chk("rst_flags",     64'({zero, sign, ovf}), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Vector table, streamed back to back
    out_ready = 1'b1;
    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt, vecs[i].vs,
           vecs[i].res, vecs[i].hi, vecs[i].ovf);
    drain();

    // ADD overflow, latency 1
    send(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 32'h80000000, 32'h0, 1'b1);
    latency(lat);
    chk("add_latency", 64'(lat), 64'd1);
    drain();

    // SUB then SLT, one result per cycle
    send(4'd1, 32'h5, 32'h5, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    send(4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h1, 32'h0, 1'b0);
    chk("b2b_second_valid",  64'(out_valid), 64'd1);
    chk("b2b_second_result", 64'(result),    64'd1);
    drain();

    // SRA by variable amount 4
    send(4'd11, 32'h4, 32'h80000000, 5'd0, 1'b1, 32'hF8000000, 32'h0, 1'b0);
`ifdef ALU_BARREL_SHIFT_EN
    chk("sra_in_ready", 64'(in_ready), 64'd1);
    latency(lat);
    chk("sra_latency", 64'(lat), 64'd1);
`else
    chk("sra_in_ready", 64'(in_ready), 64'd0);
    latency(lat);
    chk("sra_latency", 64'(lat), 64'd5);
`endif
    drain();

    // MULU worst case
    send(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    chk("mul_in_ready", 64'(in_ready), 64'd0);
    latency(lat);
    chk("mul_latency", 64'(lat), 64'd33);
    drain();

    // LUI held while consumer stalls
    out_ready = 1'b0;
    send(4'd3, 32'h0, 32'h0000ABCD, 5'd0, 1'b0, 32'hABCD0000, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid",    64'(out_valid), 64'd1);
      chk("hold_result",   64'(result),    64'hABCD0000);
      chk("hold_in_ready", 64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 64'(out_valid), 64'd0);
    chk("hold_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a multiply
    send(4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result",    64'(result),    64'd0);
    chk("abort_hi",        64'(hi),        64'd0);
    chk("abort_flags",     64'({zero, sign, ovf}), 64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1 rst = 1'b0;
    send(4'd0, 32'd2, 32'd3, 5'd0, 1'b0, 32'd5, 32'h0, 1'b0);
    latency(lat);
    chk("post_rst_latency", 64'(lat), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
